// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA frame-buffer reader.
//   - default 640x480@60 Hz timing constants
//   - counter widths for the horizontal and vertical position counters
//   - vga_tag_t: per-pixel tag bits carried through the read pipeline
//   - in_range(): inclusive range test used by the timing decode
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int H_CNT_W = 10;
  localparam int V_CNT_W = 10;

  // Tag bits that travel alongside a pixel from the counters to the outputs.
  typedef struct packed {
    logic active;  // pixel lies in the visible region
    logic in_win;  // pixel lies inside the 256x256 image window
    logic hs;      // horizontal sync pulse in progress
    logic vs;      // vertical sync pulse in progress
    logic en;      // enable as sampled with this pixel
    logic sof;     // pixel (0,0)
  } vga_tag_t;

  // Inclusive range test lo <= x <= hi on counter-width values.
  function automatic logic in_range(input logic [H_CNT_W-1:0] x,
                                    input logic [H_CNT_W-1:0] lo,
                                    input logic [H_CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: stage 0 of the reader. Free-running horizontal/vertical
// position counters plus the combinational decode of the current position.
// Ports:
//   clk, reset   pixel clock, asynchronous active-low reset
//   active       position is in the visible region
//   in_win       position is inside the image window
//   hs, vs       horizontal / vertical sync pulse in progress (active high)
//   sof          position is (0,0)
//   row, col     window-relative coordinates (low 8 bits of v-Y0, h-X0)
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int X0       = 192,
  parameter int Y0       = 112
) (
  input  logic       clk,
  input  logic       reset,
  output logic       active,
  output logic       in_win,
  output logic       hs,
  output logic       vs,
  output logic       sof,
  output logic [7:0] row,
  output logic [7:0] col
);

  localparam logic [H_CNT_W-1:0] H_ZERO   = H_CNT_W'(0);
  localparam logic [H_CNT_W-1:0] H_ONE    = H_CNT_W'(1);
  localparam logic [H_CNT_W-1:0] H_LAST   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [H_CNT_W-1:0] H_END    = H_CNT_W'(H_ACTIVE);
  localparam logic [H_CNT_W-1:0] HS_FIRST = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] HS_LAST  = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [H_CNT_W-1:0] X_FIRST  = H_CNT_W'(X0);
  localparam logic [H_CNT_W-1:0] X_LAST   = H_CNT_W'(X0 + 255);

  localparam logic [V_CNT_W-1:0] V_ZERO   = V_CNT_W'(0);
  localparam logic [V_CNT_W-1:0] V_ONE    = V_CNT_W'(1);
  localparam logic [V_CNT_W-1:0] V_LAST   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [V_CNT_W-1:0] V_END    = V_CNT_W'(V_ACTIVE);
  localparam logic [V_CNT_W-1:0] VS_FIRST = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] VS_LAST  = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [V_CNT_W-1:0] Y_FIRST  = V_CNT_W'(Y0);
  localparam logic [V_CNT_W-1:0] Y_LAST   = V_CNT_W'(Y0 + 255);

  logic [H_CNT_W-1:0] h_r;
  logic [V_CNT_W-1:0] v_r;

  // Position counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_r <= H_ZERO;
      v_r <= V_ZERO;
    end else if (h_r == H_LAST) begin
      h_r <= H_ZERO;
      if (v_r == V_LAST) begin
        v_r <= V_ZERO;
      end else begin
        v_r <= v_r + V_ONE;
      end
    end else begin
      h_r <= h_r + H_ONE;
      v_r <= v_r;
    end
  end

  assign active = (h_r < H_END) && (v_r < V_END);
  assign in_win = in_range(h_r, X_FIRST, X_LAST) && in_range(v_r, Y_FIRST, Y_LAST);
  assign hs     = in_range(h_r, HS_FIRST, HS_LAST);
  assign vs     = in_range(v_r, VS_FIRST, VS_LAST);
  assign sof    = (h_r == H_ZERO) && (v_r == V_ZERO);
  // Truncation to 8 bits is the frame-buffer coordinate inside the window.
  assign row    = 8'(v_r - Y_FIRST);
  assign col    = 8'(h_r - X_FIRST);

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: reads a 256x256 8-bit grayscale frame buffer and drives
// a 640x480@60 Hz VGA DAC. Three-clock pipeline: counters -> address/tags ->
// tags (memory access) -> registered pixel, syncs and blanking.
// Ports:
//   clk, reset     pixel clock, asynchronous active-low reset
//   enable         1 = show image, 0 = black (timing keeps running)
//   mem_addr       frame-buffer read address {row, col}
//   mem_data       read data, valid one clk after mem_addr
//   red/green/blue grayscale pixel replicated on all three channels
//   hsync, vsync   active-low syncs
//   blank_n        high during the visible region
//   sync_n         constant 0
//   frame_start    one-clk pulse with the output of pixel (0,0)
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int         H_ACTIVE = VGA_H_ACTIVE,
  parameter int         H_FP     = VGA_H_FP,
  parameter int         H_SYNC   = VGA_H_SYNC,
  parameter int         H_BP     = VGA_H_BP,
  parameter int         V_ACTIVE = VGA_V_ACTIVE,
  parameter int         V_FP     = VGA_V_FP,
  parameter int         V_SYNC   = VGA_V_SYNC,
  parameter int         V_BP     = VGA_V_BP,
  parameter int         X0       = 192,
  parameter int         Y0       = 112,
  parameter logic [7:0] BORDER   = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        sync_n,
  output logic        frame_start
);

  logic       active_s;
  logic       in_win_s;
  logic       hs_s;
  logic       vs_s;
  logic       sof_s;
  logic [7:0] row_s;
  logic [7:0] col_s;

  vga_tag_t   tag0_s;
  vga_tag_t   tag1_r;
  vga_tag_t   tag2_r;
  logic [15:0] addr_r;
  logic [7:0]  pix_s;
  logic [7:0]  pix_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        blank_r;
  logic        fs_r;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .X0       (X0),
    .Y0       (Y0)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .active (active_s),
    .in_win (in_win_s),
    .hs     (hs_s),
    .vs     (vs_s),
    .sof    (sof_s),
    .row    (row_s),
    .col    (col_s)
  );

  // Stage-0 tag: enable is captured here so a change only affects new pixels.
  always_comb begin
    tag0_s        = '0;
    tag0_s.active = active_s;
    tag0_s.in_win = in_win_s;
    tag0_s.hs     = hs_s;
    tag0_s.vs     = vs_s;
    tag0_s.en     = enable;
    tag0_s.sof    = sof_s;
  end

  // Stage 1: issue the read address; it holds outside the window or when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag1_r <= '0;
      addr_r <= 16'h0000;
    end else begin
      tag1_r <= tag0_s;
      if (in_win_s && enable) begin
        addr_r <= {row_s, col_s};
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Stage 2: tags wait here while the memory returns the pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag2_r <= '0;
    end else begin
      tag2_r <= tag1_r;
    end
  end

  // Pixel select: blanking overrides disable, which overrides window/border.
  always_comb begin
    pix_s = 8'h00;
    if (!tag2_r.active) begin
      pix_s = 8'h00;
    end else if (!tag2_r.en) begin
      pix_s = 8'h00;
    end else if (tag2_r.in_win) begin
      pix_s = mem_data;
    end else begin
      pix_s = BORDER;
    end
  end

  // Stage 3: output registers, all aligned to the same pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_r   <= 8'h00;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
      blank_r <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      pix_r   <= pix_s;
      hsync_r <= ~tag2_r.hs;
      vsync_r <= ~tag2_r.vs;
      blank_r <= tag2_r.active;
      fs_r    <= tag2_r.sof;
    end
  end

  assign mem_addr    = addr_r;
  assign red         = pix_r;
  assign green       = pix_r;
  assign blue        = pix_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign blank_n     = blank_r;
  assign sync_n      = 1'b0;
  assign frame_start = fs_r;

endmodule
